// File: rtl/mixer_pkg.sv
// Shared constants, FSM state type and quotient saturation for the mix controller slice.
package mixer_pkg;
   localparam int NUM_CH    = 12;
   localparam int SAMPLE_W  = 8;
   localparam int SUM_W     = 12;
   localparam int COUNT_W   = 4;
   localparam int DIV_STEPS = 12;
   localparam logic [SAMPLE_W-1:0] SILENCE = 8'h80;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DIVIDE  = 2'd2,
      DONE    = 2'd3
   } mix_state_t;

   // Averages never legitimately exceed 8 bits; clamp rather than wrap if they do.
   function automatic logic [SAMPLE_W-1:0] sat_quotient(input logic [SUM_W-1:0] q);
      return (|q[SUM_W-1:SAMPLE_W]) ? {SAMPLE_W{1'b1}} : q[SAMPLE_W-1:0];
   endfunction
endpackage

// File: rtl/mix_controller_if.sv
// Tick/enable/result bundle between the mix controller, its host and the signal mixer.
interface mix_controller_if;
   import mixer_pkg::*;

   logic                sample_tick;
   logic [NUM_CH-1:0]   channel_enable;
   logic [SUM_W-1:0]    mix_sum;
   logic [COUNT_W-1:0]  mix_count;
   logic [NUM_CH-1:0]   sample_enable;
   logic [SAMPLE_W-1:0] sample_out;
   logic                sample_valid;
   logic                busy;
   logic                overrun;

   modport master (
      output sample_tick, channel_enable, mix_sum, mix_count,
      input  sample_enable, sample_out, sample_valid, busy, overrun
   );

   modport slave (
      input  sample_tick, channel_enable, mix_sum, mix_count,
      output sample_enable, sample_out, sample_valid, busy, overrun
   );
endinterface

// File: rtl/mix_controller_divider.sv
// Restoring unsigned divider, one quotient bit per cycle for DIV_STEPS cycles after start.
// done is combinational: high in the cycle whose closing edge writes the final quotient bit.
module mix_divider
   import mixer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [SUM_W-1:0]   dividend,
   input  logic [COUNT_W-1:0] divisor,
   output logic [SUM_W-1:0]   quotient,
   output logic               done
);
   localparam logic [COUNT_W-1:0] STEPS = COUNT_W'(DIV_STEPS);

   logic [SUM_W-1:0]   quo_q;
   logic [COUNT_W-1:0] rem_q;
   logic [COUNT_W-1:0] div_q;
   logic [COUNT_W-1:0] step_q;
   logic [COUNT_W:0]   trial;
   logic [COUNT_W:0]   diff;
   logic               fits;

   assign trial = {rem_q, quo_q[SUM_W-1]};
   assign diff  = trial - {1'b0, div_q};
   assign fits  = (trial >= {1'b0, div_q});

   // Remainder stays below the divisor, so it always fits back into COUNT_W bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q  <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         step_q <= '0;
      end else if (start) begin
         quo_q  <= dividend;
         rem_q  <= '0;
         div_q  <= divisor;
         step_q <= STEPS;
      end else if (step_q != '0) begin
         step_q <= step_q - 1'b1;
         quo_q  <= {quo_q[SUM_W-2:0], fits};
         rem_q  <= fits ? diff[COUNT_W-1:0] : trial[COUNT_W-1:0];
      end
   end

   assign quotient = quo_q;
   assign done     = (step_q == COUNT_W'(1));
endmodule

// File: rtl/mix_controller.sv
// Averages the mixer sum over the active channel count on each accepted sample_tick.
// Latency 14 cycles tick-to-valid via the divider, 2 for 0/1 channels; no back-pressure, busy ticks dropped into overrun.
module mix_controller
   import mixer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   mix_controller_if.slave  mix
);
   mix_state_t          state_q, state_d;
   logic                div_start;
   logic                div_done;
   logic [SUM_W-1:0]    quotient;
   logic [SAMPLE_W-1:0] sum_lo_q;
   logic [COUNT_W-1:0]  count_q;
   logic [NUM_CH-1:0]   enable_q;
   logic [SAMPLE_W-1:0] out_q;
   logic                valid_q;
   logic                overrun_q;
   logic [SAMPLE_W-1:0] result;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      case (state_q)
         IDLE:    if (mix.sample_tick) state_d = CAPTURE;
         CAPTURE: begin
            div_start = (mix.mix_count >= COUNT_W'(2));
            state_d   = div_start ? DIVIDE : DONE;
         end
         DIVIDE:  if (div_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   mix_divider u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (mix.mix_sum),
      .divisor  (mix.mix_count),
      .quotient (quotient),
      .done     (div_done)
   );

   always_comb begin
      result = sat_quotient(quotient);
      if (count_q == '0)             result = SILENCE;
      else if (count_q == COUNT_W'(1)) result = sum_lo_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q  <= '0;
         out_q     <= SILENCE;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         sum_lo_q  <= '0;
         count_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         if (mix.sample_tick) begin
            if (state_q == IDLE) enable_q  <= mix.channel_enable;
            else                 overrun_q <= 1'b1;
         end
         if (state_q == CAPTURE) begin
            sum_lo_q <= mix.mix_sum[SAMPLE_W-1:0];
            count_q  <= mix.mix_count;
         end
         if (state_q == DONE) begin
            out_q   <= result;
            valid_q <= 1'b1;
         end
      end
   end

   assign mix.sample_enable = enable_q;
   assign mix.sample_out    = out_q;
   assign mix.sample_valid  = valid_q;
   assign mix.busy          = (state_q != IDLE);
   assign mix.overrun       = overrun_q;
endmodule

// File: tb/tb_mix_controller.sv
// Directed bench for mix_controller with a behavioural signal mixer on sample_enable.
module tb_mix_controller;
   logic clk;
   logic rst;
   logic [7:0]  samples [12];
   logic        ovr;
   logic [11:0] ovr_sum;
   logic [3:0]  ovr_cnt;
   int checks;
   int failures;

   mix_controller_if ifc ();
   mix_controller dut (.clk(clk), .rst(rst), .mix(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      int s;
      int c;
      s = 0;
      c = 0;
      for (int i = 0; i < 12; i++) begin
         if (ifc.sample_enable[i]) begin
            s += int'(samples[i]);
            c++;
         end
      end
      ifc.mix_sum   = ovr ? ovr_sum : 12'(s);
      ifc.mix_count = ovr ? ovr_cnt : 4'(c);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_tick(input logic [11:0] en);
      ifc.channel_enable = en;
      ifc.sample_tick    = 1'b1;
      @(posedge clk);
      #1 ifc.sample_tick = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 99;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (ifc.sample_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic [11:0] en, input int exp_lat, input logic [7:0] exp_out);
      int lat;
      do_tick(en);
      wait_valid(lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_out"}, ifc.sample_out, exp_out);
   endtask

   initial begin
      int vcnt;
      logic [7:0] last_out;
      checks = 0;
      failures = 0;
      ovr = 1'b0;
      ovr_sum = '0;
      ovr_cnt = '0;
      for (int i = 0; i < 12; i++) samples[i] = 8'd0;
      ifc.sample_tick = 1'b0;
      ifc.channel_enable = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", ifc.sample_out, 8'h80);
      chk("rst_en", ifc.sample_enable, 12'h000);
      chk("rst_busy", ifc.busy, 1'b0);
      chk("rst_overrun", ifc.overrun, 1'b0);
      chk("rst_valid", ifc.sample_valid, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      samples[0] = 8'd200;
      samples[1] = 8'd100;
      run("avg2", 12'h003, 14, 8'd150);
      chk("avg2_en", ifc.sample_enable, 12'h003);
      @(negedge clk);
      chk("avg2_pulse", ifc.sample_valid, 1'b0);
      chk("avg2_idle", ifc.busy, 1'b0);

      run("cnt0", 12'h000, 2, 8'h80);
      samples[11] = 8'd77;
      run("cnt1", 12'h800, 2, 8'd77);

      for (int i = 0; i < 12; i++) samples[i] = 8'd255;
      run("all12", 12'hFFF, 14, 8'd255);

      samples[0] = 8'd10;
      samples[1] = 8'd10;
      samples[2] = 8'd11;
      run("trunc3", 12'h007, 14, 8'd10);

      ovr = 1'b1;
      ovr_sum = 12'd4095;
      ovr_cnt = 4'd2;
      run("sat", 12'h003, 14, 8'hFF);
      ovr_sum = 12'd3000;
      ovr_cnt = 4'd15;
      run("cnt15", 12'h003, 14, 8'd200);
      ovr = 1'b0;

      // Second tick lands mid-divide and must be swallowed.
      samples[0] = 8'd200;
      samples[1] = 8'd100;
      do_tick(12'h003);
      repeat (5) @(posedge clk);
      @(negedge clk);
      ifc.channel_enable = 12'hFFF;
      ifc.sample_tick = 1'b1;
      @(posedge clk);
      #1 ifc.sample_tick = 1'b0;
      @(negedge clk);
      chk("ovr_flag", ifc.overrun, 1'b1);
      chk("ovr_en", ifc.sample_enable, 12'h003);
      chk("ovr_busy", ifc.busy, 1'b1);
      vcnt = 0;
      last_out = 8'h00;
      repeat (20) begin
         @(negedge clk);
         if (ifc.sample_valid) begin
            vcnt++;
            last_out = ifc.sample_out;
         end
      end
      chk("ovr_vcnt", vcnt, 1);
      chk("ovr_out", last_out, 8'd150);
      chk("ovr_sticky", ifc.overrun, 1'b1);
      chk("ovr_en_after", ifc.sample_enable, 12'h003);

      do_tick(12'h003);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("abort_pre_busy", ifc.busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", ifc.busy, 1'b0);
      chk("abort_out", ifc.sample_out, 8'h80);
      chk("abort_valid", ifc.sample_valid, 1'b0);
      chk("abort_overrun", ifc.overrun, 1'b0);
      chk("abort_en", ifc.sample_enable, 12'h000);
      vcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (ifc.sample_valid) vcnt++;
      end
      chk("abort_vcnt", vcnt, 0);
      chk("abort_hold", ifc.sample_out, 8'h80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end
endmodule
